// File: rtl/gate_bist_engine.sv
// Built-in self-test engine that sweeps every input pattern of a small gate and checks its truth table.
// Optional: define GATE_BIST_STOP_ON_FAIL_EN to end the run at the first mismatching index.
module gate_bist_engine #(
    parameter int                    N_IN   = 2,
    parameter int                    SETTLE = 1,
    parameter logic [(1<<N_IN)-1:0]  EXPECT = 4'b0111
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic [N_IN-1:0]         dut_in,
    input  logic                    dut_out,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [(1<<N_IN)-1:0]    captured,
    output logic [N_IN:0]           fail_cnt,
    output logic [N_IN-1:0]         fail_idx
);

    localparam int NUM_IDX    = 1 << N_IN;
    localparam int SETTLE_EFF = (SETTLE < 1) ? 1 : SETTLE;
    localparam int CW         = (SETTLE_EFF > 1) ? $clog2(SETTLE_EFF) : 1;
    localparam logic [CW-1:0]   CNT_RELOAD = CW'(SETTLE_EFF - 1);
    localparam logic [N_IN-1:0] IDX_MAX    = N_IN'(NUM_IDX - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t              state, state_n;
    logic [N_IN-1:0]     idx, idx_n;
    logic [CW-1:0]       cnt, cnt_n;
    logic [N_IN-1:0]     dut_in_n;
    logic                busy_n;
    logic                pass_n;
    logic [NUM_IDX-1:0]  captured_n;
    logic [N_IN:0]       fail_cnt_n;
    logic [N_IN-1:0]     fail_idx_n;
    logic                mismatch;
    logic                stop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            idx      <= '0;
            cnt      <= '0;
            dut_in   <= '0;
            busy     <= 1'b0;
            pass     <= 1'b0;
            captured <= '0;
            fail_cnt <= '0;
            fail_idx <= '0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            cnt      <= cnt_n;
            dut_in   <= dut_in_n;
            busy     <= busy_n;
            pass     <= pass_n;
            captured <= captured_n;
            fail_cnt <= fail_cnt_n;
            fail_idx <= fail_idx_n;
        end
    end

    // pass is resolved on the SAMPLE->DONE transition so it already includes the last sample during the done pulse
    always_comb begin
        state_n    = state;
        idx_n      = idx;
        cnt_n      = cnt;
        dut_in_n   = dut_in;
        busy_n     = busy;
        pass_n     = pass;
        captured_n = captured;
        fail_cnt_n = fail_cnt;
        fail_idx_n = fail_idx;
        mismatch   = 1'b0;
        stop       = 1'b0;
        done       = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    idx_n      = '0;
                    dut_in_n   = '0;
                    cnt_n      = CNT_RELOAD;
                    captured_n = '0;
                    fail_cnt_n = '0;
                    fail_idx_n = '0;
                    pass_n     = 1'b0;
                    busy_n     = 1'b1;
                    state_n    = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt == '0) begin
                    state_n = S_SAMPLE;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            S_SAMPLE: begin
                captured_n[idx] = dut_out;
                mismatch        = (dut_out != EXPECT[idx]);
                if (mismatch) begin
                    fail_cnt_n = fail_cnt + 1'b1;
                    if (fail_cnt == '0) begin
                        fail_idx_n = idx;
                    end
                end
`ifdef GATE_BIST_STOP_ON_FAIL_EN
                stop = (idx == IDX_MAX) || mismatch;
`else
                stop = (idx == IDX_MAX);
`endif
                if (stop) begin
                    pass_n  = (fail_cnt_n == '0);
                    state_n = S_DONE;
                end else begin
                    idx_n    = idx + 1'b1;
                    dut_in_n = idx + 1'b1;
                    cnt_n    = CNT_RELOAD;
                    state_n  = S_SETTLE;
                end
            end
            S_DONE: begin
                done     = 1'b1;
                pass_n   = (fail_cnt == '0);
                busy_n   = 1'b0;
                dut_in_n = '0;
                state_n  = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_gate_bist_engine.sv
// Self-checking bench for gate_bist_engine: table of gate models run through a scoreboard, plus reset-abort and SETTLE=3 sequences.
module tb_gate_bist_engine;

    localparam int LIMIT = 60;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] dut_in;
    logic       dut_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] captured;
    logic [2:0] fail_cnt;
    logic [1:0] fail_idx;
    logic [3:0] model;

    logic       start3;
    logic [1:0] dut_in3;
    logic       dut_out3;
    logic       busy3;
    logic       done3;
    logic       pass3;
    logic [3:0] captured3;
    logic [2:0] fail_cnt3;
    logic [1:0] fail_idx3;
    logic [3:0] model3;

    always #5 clk = ~clk;

    assign dut_out  = model[dut_in];
    assign dut_out3 = model3[dut_in3];

    gate_bist_engine #(.N_IN(2), .SETTLE(1), .EXPECT(4'b0111)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dut_in(dut_in), .dut_out(dut_out),
        .busy(busy), .done(done), .pass(pass), .captured(captured),
        .fail_cnt(fail_cnt), .fail_idx(fail_idx)
    );

    gate_bist_engine #(.N_IN(2), .SETTLE(3), .EXPECT(4'b0111)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .dut_in(dut_in3), .dut_out(dut_out3),
        .busy(busy3), .done(done3), .pass(pass3), .captured(captured3),
        .fail_cnt(fail_cnt3), .fail_idx(fail_idx3)
    );

    typedef struct {
        logic [3:0] model;
        logic [3:0] cap;
        logic [2:0] fc;
        logic [1:0] fi;
        logic       pass;
        int         lat;
    } vec_t;

    typedef struct {
        logic [3:0] cap;
        logic [2:0] fc;
        logic [1:0] fi;
        logic       pass;
        int         lat;
    } exp_t;

    exp_t       sb[$];
    logic [1:0] trace[$];
    vec_t       vecs[7];
    int         total = 0;
    int         bad   = 0;

    task automatic check_output(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Pulses start, waits for done (bounded) and compares against the queued expectation
    task automatic apply_stimulus(input logic [3:0] m, input exp_t e, input bit check_seq);
        exp_t got;
        int   lat;
        bit   seen;
        bit   ok;
        model = m;
        sb.push_back(e);
        trace.delete();
        lat  = 0;
        seen = 1'b0;
        @(posedge clk); #1 start = 1'b1;
        @(negedge clk);
        @(posedge clk); #1 start = 1'b0;
        for (int n = 1; n <= LIMIT; n++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                lat  = n;
                break;
            end
            if (busy) trace.push_back(dut_in);
        end
        got = sb.pop_front();
        if (!seen) begin
            check_output("done_timeout", 0, 1);
            return;
        end
        check_output("captured", captured, got.cap);
        check_output("fail_cnt", fail_cnt, got.fc);
        check_output("fail_idx", fail_idx, got.fi);
        check_output("pass", pass, got.pass);
        check_output("latency", lat, got.lat);
        check_output("busy_in_done", busy, 1);
        if (check_seq) begin
            ok = (trace.size() == 8);
            for (int i = 0; i < trace.size(); i++) begin
                if (trace[i] != 2'(i / 2)) ok = 1'b0;
            end
            check_output("dut_in_seq", ok, 1);
        end
        @(negedge clk);
        check_output("done_width", done, 0);
        repeat (2) @(negedge clk);
        check_output("hold_captured", captured, got.cap);
        check_output("hold_fail_cnt", fail_cnt, got.fc);
        check_output("hold_pass", pass, got.pass);
        check_output("idle_busy", busy, 0);
        check_output("idle_dut_in", dut_in, 0);
    endtask

    initial begin
        exp_t e;
        int   seen_done;
        int   lat3;
        int   dones3;
        bit   ok;

        vecs[0] = '{4'b0111, 4'b0111, 3'd0, 2'd0, 1'b1, 9};
`ifdef GATE_BIST_STOP_ON_FAIL_EN
        vecs[1] = '{4'b1000, 4'b0000, 3'd1, 2'd0, 1'b0, 3};
        vecs[2] = '{4'b1111, 4'b1111, 3'd1, 2'd3, 1'b0, 9};
        vecs[3] = '{4'b0101, 4'b0001, 3'd1, 2'd1, 1'b0, 5};
        vecs[4] = '{4'b0110, 4'b0000, 3'd1, 2'd0, 1'b0, 3};
        vecs[5] = '{4'b0001, 4'b0001, 3'd1, 2'd1, 1'b0, 5};
        vecs[6] = '{4'b0000, 4'b0000, 3'd1, 2'd0, 1'b0, 3};
`else
        vecs[1] = '{4'b1000, 4'b1000, 3'd4, 2'd0, 1'b0, 9};
        vecs[2] = '{4'b1111, 4'b1111, 3'd1, 2'd3, 1'b0, 9};
        vecs[3] = '{4'b0101, 4'b0101, 3'd1, 2'd1, 1'b0, 9};
        vecs[4] = '{4'b0110, 4'b0110, 3'd1, 2'd0, 1'b0, 9};
        vecs[5] = '{4'b0001, 4'b0001, 3'd2, 2'd1, 1'b0, 9};
        vecs[6] = '{4'b0000, 4'b0000, 3'd3, 2'd0, 1'b0, 9};
`endif

        rst_n  = 1'b0;
        start  = 1'b0;
        start3 = 1'b0;
        model  = 4'b0111;
        model3 = 4'b0111;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("rst_busy", busy, 0);
        check_output("rst_done", done, 0);
        check_output("rst_pass", pass, 0);
        check_output("rst_captured", captured, 0);
        check_output("rst_fail_cnt", fail_cnt, 0);
        check_output("rst_fail_idx", fail_idx, 0);
        check_output("rst_dut_in", dut_in, 0);
        check_output("rst_captured3", captured3, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            e = '{vecs[i].cap, vecs[i].fc, vecs[i].fi, vecs[i].pass, vecs[i].lat};
            apply_stimulus(vecs[i].model, e, i == 0);
        end

        // Reset while dut_in==2 aborts the run without a done pulse
        model = 4'b0111;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < LIMIT; n++) begin
            @(negedge clk);
            if (dut_in == 2'd2) begin
                ok = 1'b1;
                break;
            end
        end
        check_output("reach_idx2", ok, 1);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check_output("abort_busy", busy, 0);
        check_output("abort_done", done, 0);
        check_output("abort_dut_in", dut_in, 0);
        check_output("abort_captured", captured, 0);
        check_output("abort_fail_cnt", fail_cnt, 0);
        check_output("abort_pass", pass, 0);
        seen_done = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        check_output("abort_no_done", seen_done, 0);
        e = '{4'b0111, 3'd0, 2'd0, 1'b1, 9};
        apply_stimulus(4'b0111, e, 1'b1);

        // SETTLE=3 instance: second start while busy is ignored
        trace.delete();
        lat3   = 0;
        dones3 = 0;
        @(posedge clk); #1 start3 = 1'b1;
        @(negedge clk);
        @(posedge clk); #1 start3 = 1'b0;
        for (int n = 1; n <= LIMIT; n++) begin
            @(negedge clk);
            if (n == 3) start3 = 1'b1;
            if (n == 4) start3 = 1'b0;
            if (done3) begin
                dones3++;
                if (lat3 == 0) lat3 = n;
                check_output("s3_captured", captured3, 4'b0111);
                check_output("s3_pass", pass3, 1);
                check_output("s3_fail_cnt", fail_cnt3, 0);
            end else if (busy3) begin
                trace.push_back(dut_in3);
            end
        end
        check_output("s3_done_count", dones3, 1);
        check_output("s3_latency", lat3, 17);
        ok = (trace.size() == 16);
        for (int i = 0; i < trace.size(); i++) begin
            if (trace[i] != 2'(i / 4)) ok = 1'b0;
        end
        check_output("s3_dut_in_seq", ok, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
